encryption_scheduler: RTL and testbench

- Shares one elliptic-curve ElGamal `Encryption` core between two requesters and sequences it.
- Arbitrates requests round-robin and loads the winner's plaintext point.
- Restarts the core by pulsing its active-high `reset`, then waits for `Encryption_complete`.
- Returns both ciphertext points (C1, C2) to the winner over a valid/ready handshake, tagged with the requester ID.

---
 rtl/encryption_scheduler_if.sv | 38 +++
 rtl/encryption_scheduler.sv | 135 +++++++++++++
 tb/tb_encryption_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/encryption_scheduler_if.sv
// Bundles requester, response and core-facing signals of the encryption scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface encryption_scheduler_if #(
  parameter int N = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3*N-1:0]   req0_p;
  logic             req1_valid;
  logic             req1_ready;
  logic [3*N-1:0]   req1_p;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [3*N-1:0]   rsp_c1;
  logic [3*N-1:0]   rsp_c2;
  logic             rsp_err;
  logic             core_reset;
  logic [3*N-1:0]   core_p;
  logic [3*N-1:0]   core_g;
  logic [3*N-1:0]   core_c1;
  logic [3*N-1:0]   core_c2;
  logic             core_done;

  modport slave (
    input  req0_valid, req0_p, req1_valid, req1_p, rsp_ready,
           core_c1, core_c2, core_done,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_c1, rsp_c2,
           rsp_err, core_reset, core_p, core_g
  );

  modport master (
    output req0_valid, req0_p, req1_valid, req1_p, rsp_ready,
           core_c1, core_c2, core_done,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_c1, rsp_c2,
           rsp_err, core_reset, core_p, core_g
  );
endinterface

// File: rtl/encryption_scheduler.sv
// Round-robin scheduler sharing one ElGamal Encryption core between two requesters.
// Defining ENC_TIMEOUT_EN adds a RUN-state timeout that aborts with rsp_err.
module encryption_scheduler #(
  parameter int           N       = 3,
  parameter logic [N-1:0] G_X     = 3'b110,
  parameter logic [N-1:0] G_Y     = 3'b001,
  parameter logic [N-1:0] G_Z     = 3'b001,
  parameter int           TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  encryption_scheduler_if.slave bus
);
  localparam int W = 3 * N;

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t       state;
  state_t       next_state;
  logic         ptr;
  logic         grant;
  logic         grant_valid;
  logic         expire;
  logic         id_q;
  logic [W-1:0] core_p_q;
  logic [W-1:0] c1_q;
  logic [W-1:0] c2_q;

  // Grant is only offered in IDLE; ptr breaks ties when both requesters are valid.
  always_comb begin
    grant       = ptr;
    grant_valid = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant       = ptr;
        grant_valid = 1'b1;
      end else if (bus.req0_valid) begin
        grant       = 1'b0;
        grant_valid = 1'b1;
      end else if (bus.req1_valid) begin
        grant       = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (grant_valid) next_state = START;
      START: next_state = RUN;
      RUN:   if (bus.core_done || expire) next_state = RESP;
      RESP:  if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The core is held in reset while idle so it samples the new plaintext before RUN.
  always_comb begin
    bus.req0_ready = grant_valid && !grant;
    bus.req1_ready = grant_valid && grant;
    bus.core_reset = (state == IDLE) || (state == START);
    bus.rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= 1'b0;
      id_q     <= 1'b0;
      core_p_q <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
    end else begin
      if (grant_valid) begin
        core_p_q <= grant ? bus.req1_p : bus.req0_p;
        id_q     <= grant;
        ptr      <= ~grant;
      end
      if (state == RUN) begin
        if (bus.core_done) begin
          c1_q <= bus.core_c1;
          c2_q <= bus.core_c2;
        end else if (expire) begin
          c1_q <= '0;
          c2_q <= '0;
        end
      end
    end
  end

`ifdef ENC_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] timer;
  logic          err_q;

  // Timer restarts in START so it counts RUN cycles of the current job only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            timer <= '0;
    else if (state == START) timer <= '0;
    else if (state == RUN)   timer <= timer + 1'b1;
  end

  assign expire = (state == RUN) && (timer == TW'(TIMEOUT - 1));

  // A core_done arriving on the expiry cycle takes precedence over the abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state == RUN) begin
      if (bus.core_done)  err_q <= 1'b0;
      else if (expire)    err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign expire      = 1'b0;
  assign bus.rsp_err = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign bus.core_p = core_p_q;
  assign bus.core_g = {G_X, G_Y, G_Z};
  assign bus.rsp_id = id_q;
  assign bus.rsp_c1 = c1_q;
  assign bus.rsp_c2 = c2_q;
endmodule

// File: tb/tb_encryption_scheduler.sv
// Scoreboard bench for encryption_scheduler with a behavioural core model.
// Build with ENC_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_encryption_scheduler;
  localparam int N   = 3;
  localparam int W   = 3 * N;
  // rsp_valid is first visible in cycle T+23, which begins 22 edges after accept edge T.
  localparam int LAT = 22;
`ifdef ENC_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  typedef struct {
    logic         id;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic         err;
    int           due;
  } exp_t;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b0;
  int     cyc     = 0;
  int     checks  = 0;
  int     failures = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  logic   prev_valid = 1'b0;
  bit     force_done = 1'b0;
  bit     never_done = 1'b0;
  logic [4:0] mcnt = '0;
  int     t_a;
  int     t_b;
  int     h;
  int     seen;
  bit     got;

  encryption_scheduler_if #(.N(N)) bus();

  encryption_scheduler #(
    .N(N), .G_X(3'b110), .G_Y(3'b001), .G_Z(3'b001), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done 20 cycles after core_reset falls, C1 = P, C2 = ~P.
  always @(posedge clk) begin
    if (bus.core_reset)   mcnt <= '0;
    else if (mcnt != 20)  mcnt <= mcnt + 1'b1;
  end

  assign bus.core_done = force_done || (!never_done && !bus.core_reset && (mcnt == 5'd20));
  assign bus.core_c1   = bus.core_p;
  assign bus.core_c2   = ~bus.core_p;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [W-1:0] p0, input logic [W-1:0] p1,
                               input logic exp_id,
                               input logic [W-1:0] exp_c1, input logic [W-1:0] exp_c2,
                               input logic exp_err, input int lat, output int t_acc);
    exp_t e;
    bit   ok;
    ok    = 1'b0;
    t_acc = -1;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_p     = p0;
    bus.req1_p     = p1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((exp_id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      return;
    end
    checkOutput("loser_ready", exp_id ? bus.req0_ready : bus.req1_ready, 32'd0);
    @(posedge clk);
    #1;
    t_acc  = cyc;
    e.id   = exp_id;
    e.c1   = exp_c1;
    e.c2   = exp_c2;
    e.err  = exp_err;
    e.due  = cyc + lat;
    sb.push_back(e);
    if (exp_id) bus.req1_valid = 1'b0;
    else        bus.req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.rsp_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain", ok, 32'd1);
  endtask

  // Monitor: every rising rsp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.rsp_valid === 1'b1 && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("rsp_id", bus.rsp_id, mon_e.id);
          checkOutput("rsp_c1", bus.rsp_c1, mon_e.c1);
          checkOutput("rsp_c2", bus.rsp_c2, mon_e.c2);
          checkOutput("rsp_err", bus.rsp_err, mon_e.err);
          checkOutput("rsp_cycle", cyc, mon_e.due);
        end
      end
      prev_valid <= bus.rsp_valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_p     = 9'b001_001_001;
    bus.req1_p     = 9'b010_010_001;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("reset_core_reset", bus.core_reset, 32'd1);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 32'd0);
    checkOutput("reset_rsp_id", bus.rsp_id, 32'd0);
    checkOutput("reset_rsp_c1", bus.rsp_c1, 32'd0);
    checkOutput("reset_rsp_c2", bus.rsp_c2, 32'd0);
    checkOutput("reset_rsp_err", bus.rsp_err, 32'd0);
    checkOutput("reset_core_p", bus.core_p, 32'd0);
    checkOutput("core_g", bus.core_g, 32'h189);
    checkOutput("reset_req0_ready", bus.req0_ready, 32'd1);
    checkOutput("reset_req1_ready", bus.req1_ready, 32'd0);

    // Contention at reset exit: req0 first, then req1 with no bubble.
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 9'b001_001_001, 9'b010_010_001, 1'b0,
                  9'b001_001_001, 9'b110_110_110, 1'b0, LAT, t_a);
    checkOutput("busy_req1_ready", bus.req1_ready, 32'd0);
    applyStimulus(1'b0, 1'b1, 9'b001_001_001, 9'b010_010_001, 1'b1,
                  9'b010_010_001, 9'b101_101_110, 1'b0, LAT, t_b);
    checkOutput("zero_bubble", t_b, t_a + 24);
    waitDrain();

    // Both re-asserted: pointer favours req0, then req1 follows.
    applyStimulus(1'b1, 1'b1, 9'b001_001_001, 9'b010_010_001, 1'b0,
                  9'b001_001_001, 9'b110_110_110, 1'b0, LAT, t_a);
    applyStimulus(1'b0, 1'b1, 9'b001_001_001, 9'b010_010_001, 1'b1,
                  9'b010_010_001, 9'b101_101_110, 1'b0, LAT, t_b);
    waitDrain();

    applyStimulus(1'b1, 1'b0, 9'b011_011_001, 9'b000_000_000, 1'b0,
                  9'b011_011_001, 9'b100_100_110, 1'b0, LAT, t_a);
    waitDrain();

    // Backpressure: response held for 10 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 9'b000_000_000, 9'b101_010_011, 1'b1,
                  9'b101_010_011, 9'b010_101_100, 1'b0, LAT, t_a);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("bp_rsp_arrive", got, 32'd1);
    bus.req0_valid = 1'b1;
    bus.req0_p     = 9'b111_000_001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", bus.rsp_valid, 32'd1);
      checkOutput("bp_rsp_id", bus.rsp_id, 32'd1);
      checkOutput("bp_rsp_c1", bus.rsp_c1, 32'h153);
      checkOutput("bp_rsp_c2", bus.rsp_c2, 32'h0AC);
      checkOutput("bp_req0_ready", bus.req0_ready, 32'd0);
      checkOutput("bp_req1_ready", bus.req1_ready, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    h = cyc;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 9'b111_000_001, 9'b000_000_000, 1'b0,
                  9'b111_000_001, 9'b000_111_110, 1'b0, LAT, t_a);
    checkOutput("bp_next_accept", t_a, h + 1);
    waitDrain();

    // Spurious core_done during IDLE and START must be ignored.
    force_done = 1'b1;
    @(negedge clk);
    checkOutput("spur_idle_valid", bus.rsp_valid, 32'd0);
    checkOutput("spur_idle_core_reset", bus.core_reset, 32'd1);
    applyStimulus(1'b1, 1'b0, 9'b110_101_011, 9'b000_000_000, 1'b0,
                  9'b110_101_011, 9'b001_010_100, 1'b0, LAT, t_a);
    checkOutput("spur_start_core_reset", bus.core_reset, 32'd1);
    checkOutput("spur_start_valid", bus.rsp_valid, 32'd0);
    @(negedge clk);
    checkOutput("run_core_reset", bus.core_reset, 32'd0);
    force_done = 1'b0;
    waitDrain();

    // Asynchronous reset mid-RUN discards the in-flight job.
    applyStimulus(1'b1, 1'b0, 9'b010_110_101, 9'b000_000_000, 1'b0,
                  9'b010_110_101, 9'b101_001_010, 1'b0, LAT, t_a);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("async_core_reset", bus.core_reset, 32'd1);
    checkOutput("async_rsp_valid", bus.rsp_valid, 32'd0);
    checkOutput("async_core_p", bus.core_p, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    checkOutput("lost_rsp", seen, 32'd0);

`ifdef ENC_TIMEOUT_EN
    // Core never completes: abort after 8 RUN cycles (START edge + 8 RUN edges).
    never_done = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'b001_010_011, 9'b000_000_000, 1'b0,
                  9'b000_000_000, 9'b000_000_000, 1'b1, 1 + TB_TIMEOUT, t_a);
    waitDrain();
    never_done = 1'b0;
`endif

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
